crctab_gen: RTL and testbench



---
 rtl/crctab_gen_if.sv | 24 ++
 rtl/crctab_gen.sv | 111 +++++++++++
 tb/tb_crctab_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/crctab_gen_if.sv
// Handshake bundle for the CRC slicing-table block: rebuild control, ready flag
// and NPORTS independent registered read ports.
interface crctab_gen_if #(
  parameter int WIDTH  = 32,
  parameter int NPORTS = 2
);
  logic                      regen;
  logic                      ready;
  logic [NPORTS-1:0]         rd_en;
  logic [8*NPORTS-1:0]       rd_addr;
  logic [NPORTS-1:0]         rd_valid;
  logic [WIDTH*NPORTS-1:0]   rd_data;
  logic [NPORTS-1:0]         rd_err;

  modport master (
    output regen, rd_en, rd_addr,
    input  ready, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  regen, rd_en, rd_addr,
    output ready, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/crctab_gen.sv
// CRC slicing-table generator: fills a 256-entry table T_SLICE after reset or
// regen, then serves NPORTS latency-1 read ports from it.
module crctab_gen #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(32'hEDB88320),
  parameter bit               REFLECT = 1'b1,
  parameter int               SLICE   = 0,
  parameter int               NPORTS  = 2
) (
  input  logic         clk,
  input  logic         rst,
  crctab_gen_if.slave  bus
);

  typedef enum logic {GEN, READY} state_t;

  state_t                  state;
  logic [7:0]              idx;
  logic [3:0]              step;
  logic [WIDTH-1:0]        crc;
  logic [WIDTH-1:0]        crc_start;
  logic [WIDTH-1:0]        crc_next;
  logic                    last_step;
  logic                    mem_we;
  logic                    ready;
  logic [NPORTS-1:0]       rd_valid;
  logic [NPORTS-1:0]       rd_err;
  logic [WIDTH*NPORTS-1:0] rd_data;
  logic [WIDTH-1:0]        mem [256];

  // Eight bit-steps of the CRC register with a zero data byte.
  function automatic logic [WIDTH-1:0] byte_step(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (REFLECT) r = (r >> 1) ^ (r[0] ? POLY : '0);
      else         r = (r << 1) ^ (r[WIDTH-1] ? POLY : '0);
    end
    return r;
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no latch can be inferred.
  always_comb begin
    crc_start = REFLECT ? WIDTH'(idx) : (WIDTH'(idx) << (WIDTH - 8));
    crc_next  = byte_step((step == 4'd0) ? crc_start : crc);
    last_step = (step == 4'(SLICE));
    mem_we    = (state == GEN) && last_step && !rst;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GEN;
      idx   <= '0;
      step  <= '0;
      crc   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        GEN: begin
          ready <= 1'b0;
          if (last_step) begin
            step <= '0;
            idx  <= idx + 8'd1;
            if (idx == 8'hFF) state <= READY;
          end else begin
            step <= step + 4'd1;
            crc  <= crc_next;
          end
        end
        READY: begin
          ready <= 1'b1;
          if (bus.regen) begin
            state <= GEN;
            ready <= 1'b0;
            idx   <= '0;
            step  <= '0;
          end
        end
        default: state <= GEN;
      endcase
    end
  end

  // NOTE: the table RAM has no reset; it is always rewritten before ready rises.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= crc_next;
  end

  // Reads in the regen cycle still see ready=1 and the old table contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= '0;
      rd_err   <= '0;
      rd_data  <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        rd_valid[p] <= bus.rd_en[p] & ready;
        rd_err[p]   <= bus.rd_en[p] & ~ready;
        if (bus.rd_en[p] && ready)
          rd_data[p*WIDTH +: WIDTH] <= mem[bus.rd_addr[p*8 +: 8]];
      end
    end
  end

  assign bus.ready    = ready;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_err   = rd_err;
  assign bus.rd_data  = rd_data;

endmodule

// File: tb/tb_crctab_gen.sv
// Directed bench for crctab_gen: three instances (LSB-first T_0, LSB-first T_1,
// MSB-first T_0) checked against a byte-table slicing model.
module tb_crctab_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_en = '0;
  logic [15:0] rd_addr = '0;
  logic        regen_d = 1'b0, regen_s = 1'b0, regen_m = 1'b0;

  int checks = 0;
  int passes = 0;

  logic [31:0] t0_r [256];
  logic [31:0] t1_r [256];
  logic [31:0] t0_m [256];

  always #5 clk = ~clk;

  crctab_gen_if #(.WIDTH(32), .NPORTS(2)) if_d ();
  crctab_gen_if #(.WIDTH(32), .NPORTS(2)) if_s ();
  crctab_gen_if #(.WIDTH(32), .NPORTS(2)) if_m ();

  assign if_d.rd_en = rd_en;  assign if_d.rd_addr = rd_addr;  assign if_d.regen = regen_d;
  assign if_s.rd_en = rd_en;  assign if_s.rd_addr = rd_addr;  assign if_s.regen = regen_s;
  assign if_m.rd_en = rd_en;  assign if_m.rd_addr = rd_addr;  assign if_m.regen = regen_m;

  crctab_gen #(.WIDTH(32), .POLY(32'hEDB88320), .REFLECT(1'b1), .SLICE(0), .NPORTS(2))
    u_d (.clk(clk), .rst(rst), .bus(if_d));
  crctab_gen #(.WIDTH(32), .POLY(32'hEDB88320), .REFLECT(1'b1), .SLICE(1), .NPORTS(2))
    u_s (.clk(clk), .rst(rst), .bus(if_s));
  crctab_gen #(.WIDTH(32), .POLY(32'h04C11DB7), .REFLECT(1'b0), .SLICE(0), .NPORTS(2))
    u_m (.clk(clk), .rst(rst), .bus(if_m));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte tables built bitwise, then T_1 derived from T_0 the slicing-by-8 way.
  task automatic build_model();
    logic [31:0] r, m;
    for (int i = 0; i < 256; i++) begin
      r = 32'(i);
      m = 32'(i) << 24;
      for (int b = 0; b < 8; b++) begin
        r = r[0]  ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        m = m[31] ? ((m << 1) ^ 32'h04C11DB7) : (m << 1);
      end
      t0_r[i] = r;
      t0_m[i] = m;
    end
    for (int i = 0; i < 256; i++)
      t1_r[i] = (t0_r[i] >> 8) ^ t0_r[t0_r[i][7:0]];
  endtask

  // Counts cycles until each instance raises ready; -1 marks a missed bound.
  // With probe set, a read is issued during the fill and regen is pulsed mid-fill.
  task automatic wait_ready(input bit probe, output int nd, output int ns, output int nm);
    int n;
    logic [63:0] snap;
    n = 0; nd = -1; ns = -1; nm = -1;
    snap = if_d.rd_data;
    while ((nd < 0 || ns < 0 || nm < 0) && n < 700) begin
      rd_en   = (probe && n == 10) ? 2'b11 : 2'b00;
      regen_d = probe && n == 20;
      regen_s = regen_d;
      regen_m = regen_d;
      tick();
      n++;
      if (probe && n == 11) begin
        check("fill_rd_err",   64'(if_d.rd_err),   64'(2'b11));
        check("fill_rd_valid", 64'(if_d.rd_valid), 64'(2'b00));
        check("fill_rd_data",  if_d.rd_data,       snap);
        check("fill_rd_err_m", 64'(if_m.rd_err),   64'(2'b11));
      end
      if (if_d.ready && nd < 0) nd = n;
      if (if_s.ready && ns < 0) ns = n;
      if (if_m.ready && nm < 0) nm = n;
    end
    rd_en = '0; regen_d = 0; regen_s = 0; regen_m = 0;
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 256; a++) begin
      rd_addr = {8'(255 - a), 8'(a)};
      rd_en   = 2'b11;
      tick();
      check({tag, "_d0"}, 64'(if_d.rd_data[31:0]),  64'(t0_r[a]));
      check({tag, "_d1"}, 64'(if_d.rd_data[63:32]), 64'(t0_r[255 - a]));
      check({tag, "_s0"}, 64'(if_s.rd_data[31:0]),  64'(t1_r[a]));
      check({tag, "_s1"}, 64'(if_s.rd_data[63:32]), 64'(t1_r[255 - a]));
      check({tag, "_m0"}, 64'(if_m.rd_data[31:0]),  64'(t0_m[a]));
      check({tag, "_m1"}, 64'(if_m.rd_data[63:32]), 64'(t0_m[255 - a]));
    end
    rd_en = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, ns, nm;
    logic [1:0]  prev_en;
    logic [15:0] prev_addr;
    logic [31:0] hd [2];
    logic [31:0] hs [2];
    logic [31:0] hm [2];

    build_model();

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ready",    64'(if_d.ready),    64'd0);
    check("rst_rd_valid", 64'(if_d.rd_valid), 64'd0);
    check("rst_rd_data",  if_d.rd_data,       64'd0);
    check("rst_rd_err",   64'(if_d.rd_err),   64'd0);

    // Initial fill with a read-during-fill probe and an ignored mid-fill regen
    rst = 1'b0;
    wait_ready(1'b1, nd, ns, nm);
    check("fill_time_d", 64'(nd), 64'd257);
    check("fill_time_s", 64'(ns), 64'd513);
    check("fill_time_m", 64'(nm), 64'd257);

    // Directed entries
    rd_addr = {8'h80, 8'h01};
    rd_en   = 2'b11;
    tick();
    rd_en = '0;
    check("dir_valid",  64'(if_d.rd_valid),      64'(2'b11));
    check("dir_err",    64'(if_d.rd_err),        64'(2'b00));
    check("dir_d_01",   64'(if_d.rd_data[31:0]), 64'h77073096);
    check("dir_d_80",   64'(if_d.rd_data[63:32]),64'hEDB88320);
    check("dir_s_01",   64'(if_s.rd_data[31:0]), 64'h191B3141);
    check("dir_m_01",   64'(if_m.rd_data[31:0]), 64'h04C11DB7);
    check("dir_m_80",   64'(if_m.rd_data[63:32]),64'h690CE0EE);
    rd_addr = {8'h00, 8'h00};
    rd_en   = 2'b01;
    tick();
    rd_en = '0;
    check("dir_d_00",   64'(if_d.rd_data[31:0]), 64'd0);
    check("dir_valid1", 64'(if_d.rd_valid),      64'(2'b01));
    check("dir_hold1",  64'(if_d.rd_data[63:32]),64'hEDB88320);
    tick();
    check("idle_valid", 64'(if_d.rd_valid),      64'(2'b00));
    check("idle_hold",  64'(if_d.rd_data[31:0]), 64'd0);

    // Full table sweep on every instance
    sweep("sweep1");

    // Random back-to-back two-port stream
    prev_en = '0; prev_addr = '0;
    hd[0] = t0_r[255]; hd[1] = t0_r[0];
    hs[0] = t1_r[255]; hs[1] = t1_r[0];
    hm[0] = t0_m[255]; hm[1] = t0_m[0];
    tick();
    for (int c = 0; c < 200; c++) begin
      prev_en   = 2'($urandom_range(0, 3));
      prev_addr = (c % 4 == 0) ? {2{8'($urandom)}} : 16'($urandom);
      rd_en     = prev_en;
      rd_addr   = prev_addr;
      tick();
      check("rand_valid", 64'(if_d.rd_valid), 64'(prev_en));
      for (int p = 0; p < 2; p++) begin
        if (prev_en[p]) begin
          hd[p] = t0_r[prev_addr[p*8 +: 8]];
          hs[p] = t1_r[prev_addr[p*8 +: 8]];
          hm[p] = t0_m[prev_addr[p*8 +: 8]];
        end
        check("rand_d", 64'(if_d.rd_data[p*32 +: 32]), 64'(hd[p]));
        check("rand_s", 64'(if_s.rd_data[p*32 +: 32]), 64'(hs[p]));
        check("rand_m", 64'(if_m.rd_data[p*32 +: 32]), 64'(hm[p]));
      end
    end
    rd_en = '0;
    tick();

    // regen in READY: the same-cycle read is served from the old table
    rd_addr = {8'h00, 8'h80};
    rd_en   = 2'b11;
    regen_d = 1'b1;
    tick();
    regen_d = 1'b0;
    rd_en   = '0;
    check("regen_ready",   64'(if_d.ready),          64'd0);
    check("regen_valid",   64'(if_d.rd_valid),       64'(2'b11));
    check("regen_rd_data", 64'(if_d.rd_data[31:0]),  64'hEDB88320);
    check("regen_other",   64'(if_s.ready),          64'd1);
    wait_ready(1'b0, nd, ns, nm);
    check("regen_time_d",  64'(nd), 64'd257);

    // Reset halfway through a fill
    regen_d = 1'b1;
    tick();
    regen_d = 1'b0;
    repeat (128) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("midrst_ready_d", 64'(if_d.ready), 64'd0);
    check("midrst_ready_m", 64'(if_m.ready), 64'd0);
    rst = 1'b0;
    wait_ready(1'b0, nd, ns, nm);
    check("midrst_time_d", 64'(nd), 64'd257);
    check("midrst_time_s", 64'(ns), 64'd513);
    check("midrst_time_m", 64'(nm), 64'd257);
    sweep("sweep2");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
